// File: rtl/uart_tx_frame_ctrl_if.sv
// rtl/uart_tx_frame_ctrl_if.sv - upstream handshake and serializer link of the UART frame sequencer
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_data;
    logic                  ser_done;
    logic                  ser_en;
    logic                  TX_OUT;
    logic                  Busy;
    logic                  frame_err;

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_en, TX_OUT, Busy, frame_err
    );

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_en, TX_OUT, Busy, frame_err
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART TX frame sequencer: start/data/parity/stop muxing with DATA watchdog
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int WDOG_SLACK = 2
) (
    input  logic               CLK,
    input  logic               RST,
    uart_tx_frame_ctrl_if.slave bus
);
    localparam int LIMIT = DATA_WIDTH + WDOG_SLACK;
    localparam int CW    = $clog2(LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_bit_cnt;
    logic          r_par_bit;
    logic          r_par_en;
    logic          r_frame_err;
    logic [CW-1:0] w_cnt_inc;
    logic          w_tx;

    assign w_cnt_inc = r_bit_cnt + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_par_bit   <= 1'b0;
            r_par_en    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Data_Valid) begin
                        r_state     <= S_START;
                        r_par_en    <= bus.PAR_EN;
                        r_par_bit   <= (^bus.P_DATA) ^ bus.PAR_TYP;
                        r_frame_err <= 1'b0;
                        r_bit_cnt   <= '0;
                    end
                end
                S_START: r_state <= S_DATA;
                S_DATA: begin
                    if (r_bit_cnt < CW'(LIMIT))
                        r_bit_cnt <= w_cnt_inc;
                    // a missing ser_done must not wedge the line low-data forever
                    if (bus.ser_done)
                        r_state <= r_par_en ? S_PARITY : S_STOP;
                    else if (w_cnt_inc >= CW'(LIMIT)) begin
                        r_state     <= S_STOP;
                        r_frame_err <= 1'b1;
                    end
                end
                S_PARITY: r_state <= S_STOP;
                S_STOP:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = bus.ser_data;
            S_PARITY: w_tx = r_par_bit;
            default:  w_tx = 1'b1;
        endcase
    end

    assign bus.TX_OUT    = w_tx;
    assign bus.ser_en    = (r_state == S_START) || (r_state == S_DATA);
    assign bus.Busy      = (r_state != S_IDLE);
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - self-checking bench for uart_tx_frame_ctrl with a stub serializer
module tb_uart_tx_frame_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   failures = 0;

    uart_tx_frame_ctrl_if bus ();

    uart_tx_frame_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // stub serializer: loads on accept, shifts LSB first while ser_en, flags bit 7
    logic [7:0] s_shreg;
    logic [3:0] s_idx;
    logic       s_bit;
    logic       s_valid;
    logic [2:0] s_cur;
    logic       done_en;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_shreg <= 8'h00;
            s_idx   <= 4'd0;
            s_bit   <= 1'b0;
            s_valid <= 1'b0;
            s_cur   <= 3'd0;
        end else if (bus.Data_Valid && !bus.Busy) begin
            s_shreg <= bus.P_DATA;
            s_idx   <= 4'd0;
            s_valid <= 1'b0;
        end else if (bus.ser_en && s_idx < 4'd8) begin
            s_bit   <= s_shreg[s_idx[2:0]];
            s_cur   <= s_idx[2:0];
            s_valid <= 1'b1;
            s_idx   <= s_idx + 4'd1;
        end
    end

    assign bus.ser_data = s_bit;
    assign bus.ser_done = done_en && s_valid && (s_cur == 3'd7);

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic        mid_dv;
        logic [0:11] exp_tx;
        int          exp_busy;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // request at a negedge, then sample 14 cycles starting with the start-bit cycle
    task automatic run_frame(input vec_t v, output logic [0:11] tx, output int nb, output int ns);
        @(negedge CLK);
        bus.P_DATA     = v.data;
        bus.PAR_EN     = v.pe;
        bus.PAR_TYP    = v.pt;
        bus.Data_Valid = 1'b1;
        nb = 0;
        ns = 0;
        tx = '1;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            if (i < 12) tx[i] = bus.TX_OUT;
            nb += int'(bus.Busy);
            ns += int'(bus.ser_en);
            bus.Data_Valid = (v.mid_dv && i == 2);
            if (i == 0) begin
                bus.PAR_EN  = ~v.pe;
                bus.PAR_TYP = ~v.pt;
                bus.P_DATA  = ~v.data;
            end
        end
    endtask

    initial begin
        logic [0:11] tx;
        logic [0:9]  txa;
        logic [0:8]  txb;
        int          nb;
        int          ns;
        vec_t        w;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 12'b0_10100101_1_11, 10};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 12'b0_10100101_0_1_1, 11};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 12'b0_10100101_1_1_1, 11};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 12'b0_10000000_0_1_1, 11};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 12'b0_00111100_1_11, 10};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b0, 12'b0_00000001_1_1_1, 11};
        vecs[6] = '{8'hA5, 1'b0, 1'b0, 1'b1, 12'b0_10100101_1_11, 10};
        vecs[7] = '{8'hC3, 1'b1, 1'b1, 1'b1, 12'b0_11000011_1_1_1, 11};

        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        done_en        = 1'b1;

        // inputs toggling while reset is held
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            bus.Data_Valid = i[0];
            bus.PAR_EN     = i[1];
            bus.PAR_TYP    = ~i[0];
            bus.P_DATA     = 8'($urandom);
            #2;
            chk($sformatf("reset_outs_%0d", i),
                {bus.TX_OUT, bus.Busy, bus.ser_en, bus.frame_err}, 4'b1000);
        end
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        chk("idle_after_reset", {bus.TX_OUT, bus.Busy, bus.ser_en}, 3'b100);

        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k], tx, nb, ns);
            chk($sformatf("v%0d_tx", k), tx, vecs[k].exp_tx);
            chk($sformatf("v%0d_busy_cycles", k), nb, vecs[k].exp_busy);
            chk($sformatf("v%0d_ser_en_cycles", k), ns, 9);
        end
        chk("no_frame_err_normal", bus.frame_err, 1'b0);

        // data in STOP is ignored, next IDLE cycle accepts
        @(negedge CLK);
        bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            txa[i] = bus.TX_OUT;
            bus.Data_Valid = 1'b0;
            if (i == 9) begin
                chk("stop_cycle_busy", bus.Busy, 1'b1);
                bus.Data_Valid = 1'b1;
                bus.P_DATA     = 8'h5A;
            end
        end
        chk("b2b_first_tx", txa, 10'b0_00111100_1);
        @(negedge CLK);
        chk("stop_dv_ignored", {bus.TX_OUT, bus.Busy}, 2'b10);
        @(negedge CLK);
        chk("accept_after_stop", {bus.TX_OUT, bus.Busy}, 2'b01);
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            txb[i] = bus.TX_OUT;
        end
        chk("b2b_second_tx", txb, 9'b01011010_1);
        repeat (3) @(negedge CLK);

        // watchdog: serializer never signals done
        done_en = 1'b0;
        w = '{8'hA5, 1'b0, 1'b0, 1'b0, 12'b0, 12};
        run_frame(w, tx, nb, ns);
        chk("wdog_busy_cycles", nb, 12);
        chk("wdog_ser_en_cycles", ns, 11);
        chk("wdog_stop_bit", tx[11], 1'b1);
        chk("wdog_frame_err", bus.frame_err, 1'b1);
        repeat (3) @(negedge CLK);
        chk("wdog_err_sticky", {bus.frame_err, bus.Busy}, 2'b10);
        done_en = 1'b1;
        run_frame(vecs[0], tx, nb, ns);
        chk("post_wdog_tx", tx, vecs[0].exp_tx);
        chk("err_cleared_by_accept", bus.frame_err, 1'b0);

        // async reset mid-frame during data bit 4
        @(negedge CLK);
        bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            bus.Data_Valid = 1'b0;
        end
        chk("pre_reset_bit4", {bus.TX_OUT, bus.Busy, bus.ser_en}, 3'b011);
        #2 RST = 1'b0;
        #1 chk("mid_reset_outs", {bus.TX_OUT, bus.Busy, bus.ser_en, bus.frame_err}, 4'b1000);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("idle_after_mid_reset", {bus.TX_OUT, bus.Busy}, 2'b10);
        run_frame(vecs[3], tx, nb, ns);
        chk("post_reset_tx", tx, vecs[3].exp_tx);
        chk("post_reset_busy", nb, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
